// File: rtl/seg_mux_scanner.sv
// seg_mux_scanner
// Time-shares one seven-segment bus across NUM_DIGITS common-anode digits.
// Each digit slot opens with a short all-anodes-off interval to suppress
// ghosting. A free-running blink generator supplies the phase used for
// per-digit blink and global flash. Output polarity is selectable.

module seg_mux_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_DIV    = 25000000,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [7*NUM_DIGITS-1:0] digit_segs,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    flash_all,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    blink_phase,
    output logic                    frame_tick
);

    localparam int SLOT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
    localparam int BLINK_W = (BLINK_DIV   > 1) ? $clog2(BLINK_DIV)   : 1;

    // Idle (all-off) pattern in output polarity; XOR with it converts
    // active-high internal values to pin polarity.
    localparam logic [6:0]            SEG_OFF   = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ACTIVE_LOW}};

    logic [SLOT_W-1:0]     slot_cnt_q,    slot_cnt_d;
    logic [IDX_W-1:0]      digit_idx_q,   digit_idx_d;
    logic [BLINK_W-1:0]    blink_cnt_q,   blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic                  frame_tick_q,  frame_tick_d;
    logic [6:0]            seg_q,         seg_d;
    logic [NUM_DIGITS-1:0] anode_q,       anode_d;

    logic                  slot_last;
    logic                  idx_last;
    logic                  blink_last;
    logic [6:0]            cur_segs;
    logic                  cur_en;
    logic                  cur_mask;
    logic                  past_blank;
    logic                  lit;
    logic                  blank;
    logic [6:0]            seg_act;
    logic [NUM_DIGITS-1:0] anode_act;

    assign slot_last  = (slot_cnt_q  == SLOT_W'(REFRESH_DIV - 1));
    assign idx_last   = (digit_idx_q == IDX_W'(NUM_DIGITS - 1));
    assign blink_last = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));

    // Scan and blink counter next-state; digit index wraps at NUM_DIGITS-1
    // so non-power-of-two digit counts never reach unused indices.
    always_comb begin
        slot_cnt_d    = slot_last ? '0 : slot_cnt_q + SLOT_W'(1);
        digit_idx_d   = digit_idx_q;
        if (slot_last) begin
            digit_idx_d = idx_last ? '0 : digit_idx_q + IDX_W'(1);
        end
        blink_cnt_d   = blink_last ? '0 : blink_cnt_q + BLINK_W'(1);
        blink_phase_d = blink_last ? ~blink_phase_q : blink_phase_q;
        frame_tick_d  = slot_last && idx_last;
    end

    // Select the pattern, enable and blink mask of the digit being scanned.
    always_comb begin
        cur_segs = '0;
        cur_en   = 1'b0;
        cur_mask = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_idx_q == IDX_W'(k)) begin
                cur_segs = digit_segs[7*k +: 7];
                cur_en   = digit_en[k];
                cur_mask = blink_mask[k];
            end
        end
    end

    // With no blanking interval every slot cycle is a lit cycle; the
    // compare is dropped so it does not degenerate into ">= 0".
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign past_blank = 1'b1;
        end else begin : g_blank
            assign past_blank = (slot_cnt_q >= SLOT_W'(BLANK_CYCLES));
        end
    endgenerate

    // Output decode. Blink uses the post-toggle phase so the segment
    // blanking lines up with the blink_phase output on the same edge.
    // A disabled digit keeps its anode off; a blink-blanked digit keeps
    // its anode on and only drops the segments.
    always_comb begin
        lit       = cur_en && past_blank;
        blank     = blink_phase_d && (cur_mask || flash_all);
        seg_act   = (lit && !blank) ? cur_segs : 7'h00;
        anode_act = lit ? (NUM_DIGITS'(1) << digit_idx_q) : '0;
        seg_d     = seg_act   ^ SEG_OFF;
        anode_d   = anode_act ^ ANODE_OFF;
    end

    // State and output registers; reset forces outputs idle immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt_q    <= '0;
            digit_idx_q   <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            frame_tick_q  <= 1'b0;
            seg_q         <= SEG_OFF;
            anode_q       <= ANODE_OFF;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            digit_idx_q   <= digit_idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            frame_tick_q  <= frame_tick_d;
            seg_q         <= seg_d;
            anode_q       <= anode_d;
        end
    end

    assign seg         = seg_q;
    assign anode       = anode_q;
    assign blink_phase = blink_phase_q;
    assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_seg_mux_scanner.sv
// Bench for seg_mux_scanner with a small scan/blink timing model and an
// expected-value queue filled as each cycle's stimulus is driven.

module tb_seg_mux_scanner;

    localparam int N  = 4;
    localparam int R  = 4;
    localparam int B  = 1;
    localparam int BD = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [7*N-1:0]    digit_segs = '0;
    logic [N-1:0]      digit_en = '1;
    logic [N-1:0]      blink_mask = '0;
    logic              flash_all = 1'b0;
    logic [6:0]        seg;
    logic [N-1:0]      anode;
    logic              blink_phase;
    logic              frame_tick;

    int                pass_cnt = 0;
    int                total_cnt = 0;
    int                edge_n = 0;
    logic [12:0]       exp_q[$];
    logic [12:0]       got;
    logic [12:0]       want;

    always #5 clk = ~clk;

    seg_mux_scanner #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .BLANK_CYCLES(B),
        .BLINK_DIV   (BD),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .digit_segs (digit_segs),
        .digit_en   (digit_en),
        .blink_mask (blink_mask),
        .flash_all  (flash_all),
        .seg        (seg),
        .anode      (anode),
        .blink_phase(blink_phase),
        .frame_tick (frame_tick)
    );

    // Expected {seg, anode, frame_tick, blink_phase} right after rising edge
    // e (e = 1 is the first edge after reset release), from the timing rules.
    function automatic logic [12:0] model(int e, logic [7*N-1:0] segs,
                                          logic [N-1:0] en, logic [N-1:0] mask,
                                          logic flash);
        int         c;
        int         slot;
        int         idx;
        logic       bp;
        logic       lit;
        logic       blank;
        logic [6:0] s;
        logic [3:0] a;
        logic       ft;
        c     = e - 1;
        slot  = c % R;
        idx   = (c / R) % N;
        bp    = ((e / BD) % 2) == 1;
        lit   = en[idx] && (slot >= B);
        blank = bp && (mask[idx] || flash);
        a     = lit ? ~(4'b0001 << idx) : 4'b1111;
        s     = (lit && !blank) ? ~segs[idx*7 +: 7] : 7'h7F;
        ft    = (e % (N*R)) == 0;
        return {s, a, ft, bp};
    endfunction

    task automatic push_expected();
        exp_q.push_back(model(edge_n + 1, digit_segs, digit_en, blink_mask, flash_all));
    endtask

    task automatic advance();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        edge_n  = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        digit_segs = {7'h4F, 7'h5B, 7'h06, 7'h3F};
        digit_en   = 4'b1111;
        blink_mask = 4'b0000;
        flash_all  = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({seg, anode, frame_tick, blink_phase} !== {7'h7F, 4'hF, 1'b0, 1'b0})
            $display("FAIL reset_idle: got seg=%h anode=%b ft=%b bp=%b, want seg=7f anode=1111 ft=0 bp=0",
                     seg, anode, frame_tick, blink_phase);
        else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        edge_n  = 0;
        exp_q.delete();
        advance();
        total_cnt++;
        if ({seg, anode} !== {7'h7F, 4'hF})
            $display("FAIL reset_edge1: got seg=%h anode=%b, want seg=7f anode=1111", seg, anode);
        else pass_cnt++;
        advance();
        total_cnt++;
        if ({seg, anode} !== {~7'h3F, 4'hE})
            $display("FAIL reset_edge2: got seg=%h anode=%b, want seg=%h anode=1110", seg, anode, ~7'h3F);
        else pass_cnt++;
    endtask

    task automatic test_basic_scan();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            push_expected();
            advance();
            want = exp_q.pop_front();
            got  = {seg, anode, frame_tick, blink_phase};
            total_cnt++;
            if (got !== want)
                $display("FAIL basic_scan e=%0d: got seg=%h an=%b ft=%b bp=%b, want seg=%h an=%b ft=%b bp=%b",
                         edge_n, got[12:6], got[5:2], got[1], got[0], want[12:6], want[5:2], want[1], want[0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_blink();
        do_reset();
        blink_mask = 4'b0001;
        for (int i = 0; i < 48; i++) begin
            push_expected();
            advance();
            want = exp_q.pop_front();
            got  = {seg, anode, frame_tick, blink_phase};
            total_cnt++;
            if (got !== want)
                $display("FAIL per_digit_blink e=%0d: got seg=%h an=%b ft=%b bp=%b, want seg=%h an=%b ft=%b bp=%b",
                         edge_n, got[12:6], got[5:2], got[1], got[0], want[12:6], want[5:2], want[1], want[0]);
            else pass_cnt++;
        end
        blink_mask = 4'b0000;
    endtask

    task automatic test_flash();
        do_reset();
        flash_all = 1'b1;
        for (int i = 0; i < 32; i++) begin
            push_expected();
            advance();
            want = exp_q.pop_front();
            got  = {seg, anode, frame_tick, blink_phase};
            total_cnt++;
            if (got !== want)
                $display("FAIL global_flash e=%0d: got seg=%h an=%b ft=%b bp=%b, want seg=%h an=%b ft=%b bp=%b",
                         edge_n, got[12:6], got[5:2], got[1], got[0], want[12:6], want[5:2], want[1], want[0]);
            else pass_cnt++;
        end
        flash_all = 1'b0;
    endtask

    task automatic test_disable();
        do_reset();
        digit_en   = 4'b1011;
        blink_mask = 4'b0100;
        for (int i = 0; i < 32; i++) begin
            push_expected();
            advance();
            want = exp_q.pop_front();
            got  = {seg, anode, frame_tick, blink_phase};
            total_cnt++;
            if (got !== want)
                $display("FAIL digit_disable e=%0d: got seg=%h an=%b ft=%b bp=%b, want seg=%h an=%b ft=%b bp=%b",
                         edge_n, got[12:6], got[5:2], got[1], got[0], want[12:6], want[5:2], want[1], want[0]);
            else pass_cnt++;
        end
        digit_en   = 4'b1111;
        blink_mask = 4'b0000;
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 11; i++) begin
            push_expected();
            advance();
            want = exp_q.pop_front();
            got  = {seg, anode, frame_tick, blink_phase};
            total_cnt++;
            if (got !== want)
                $display("FAIL mid_reset_pre e=%0d: got seg=%h an=%b ft=%b bp=%b, want seg=%h an=%b ft=%b bp=%b",
                         edge_n, got[12:6], got[5:2], got[1], got[0], want[12:6], want[5:2], want[1], want[0]);
            else pass_cnt++;
        end
        // Digit 2's second active cycle, blink phase 1
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({seg, anode, frame_tick, blink_phase} !== {7'h7F, 4'hF, 1'b0, 1'b0})
            $display("FAIL mid_reset_async: got seg=%h anode=%b ft=%b bp=%b, want seg=7f anode=1111 ft=0 bp=0",
                     seg, anode, frame_tick, blink_phase);
        else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        edge_n  = 0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            push_expected();
            advance();
            want = exp_q.pop_front();
            got  = {seg, anode, frame_tick, blink_phase};
            total_cnt++;
            if (got !== want)
                $display("FAIL mid_reset_post e=%0d: got seg=%h an=%b ft=%b bp=%b, want seg=%h an=%b ft=%b bp=%b",
                         edge_n, got[12:6], got[5:2], got[1], got[0], want[12:6], want[5:2], want[1], want[0]);
            else pass_cnt++;
            if (edge_n == 2) begin
                total_cnt++;
                if (anode !== 4'hE)
                    $display("FAIL mid_reset_digit0_edge2: got anode=%b, want 1110", anode);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_latency();
        logic [6:0] pats [3];
        pats[0] = 7'h77;
        pats[1] = 7'h7D;
        pats[2] = 7'h01;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            push_expected();
            advance();
            want = exp_q.pop_front();
            got  = {seg, anode, frame_tick, blink_phase};
            total_cnt++;
            if (got !== want)
                $display("FAIL latency_pre e=%0d: got seg=%h an=%b, want seg=%h an=%b",
                         edge_n, got[12:6], got[5:2], want[12:6], want[5:2]);
            else pass_cnt++;
        end
        for (int i = 0; i < 2; i++) begin
            digit_segs[6:0] = pats[i];
            push_expected();
            advance();
            want = exp_q.pop_front();
            got  = {seg, anode, frame_tick, blink_phase};
            total_cnt++;
            if (got !== want || seg !== ~pats[i])
                $display("FAIL latency_change e=%0d: got seg=%h an=%b, want seg=%h an=%b",
                         edge_n, got[12:6], got[5:2], ~pats[i], want[5:2]);
            else pass_cnt++;
        end
        digit_segs[6:0] = pats[2];
        push_expected();
        advance();
        want = exp_q.pop_front();
        got  = {seg, anode, frame_tick, blink_phase};
        total_cnt++;
        if (got !== want)
            $display("FAIL latency_slot_end e=%0d: got seg=%h an=%b, want seg=%h an=%b",
                     edge_n, got[12:6], got[5:2], want[12:6], want[5:2]);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_blink();
        test_flash();
        test_disable();
        test_mid_reset();
        test_latency();
        total_cnt++;
        if (exp_q.size() !== 0)
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
